// File: rtl/taxi_link_wdog_pkg.sv
// -----------------------------------------------------------------------------
// taxi_link_wdog_pkg
// Shared definitions for the Ethernet link watchdog.
//   wdog_state_t : 3-bit FSM state encoding, also driven out on the state port
//   SYNC_STAGES  : depth of the input synchronizers for the PHY status signals
// -----------------------------------------------------------------------------
package taxi_link_wdog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_RECOVER     = 3'd1,
    ST_WAIT_LOCK   = 3'd2,
    ST_WAIT_STATUS = 3'd3,
    ST_UP          = 3'd4
  } wdog_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/taxi_link_wdog_filter.sv
// -----------------------------------------------------------------------------
// taxi_link_wdog_filter
// Consecutive-cycle debounce: done is high in the cycle that is the N-th
// consecutive cycle of in=1 (and in every following cycle while in stays 1).
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   clr  : holds the run length at zero and masks done
//   in   : condition being debounced
//   done : run of N consecutive in=1 cycles completed this cycle
// -----------------------------------------------------------------------------
module taxi_link_wdog_filter #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic in,
  output logic done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (N < 1) begin : g_chk_n
    $error("taxi_link_wdog_filter: N must be at least 1");
  end

  // Run length of previous in=1 cycles, saturating at N-1 so the counter
  // never needs more bits than N itself.
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || !in) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = in && !clr && (cnt == LAST);

endmodule

// File: rtl/taxi_eth_link_wdog.sv
// -----------------------------------------------------------------------------
// taxi_eth_link_wdog
// Per-channel link watchdog and recovery sequencer for the 10G/25G MAC/PHY.
// Watches PHY block lock, high BER and RX status, pulses the MAC RX reset when
// the link does not come up in bounded time, and provides a debounced link_up.
//
// Ports:
//   clk           : control clock (xcvr_ctrl_clk)
//   rst           : asynchronous active-high reset
//   enable        : low forces IDLE and drops rx_rst_req / link_up
//   force_reset   : single-cycle request to restart the recovery sequence
//   rx_block_lock : PHY block lock (asynchronous, synchronized here)
//   rx_high_ber   : PHY high BER (asynchronous, synchronized here)
//   rx_status     : PHY link status (asynchronous, synchronized here)
//   rx_rst_req    : registered RX reset request, high while state is RECOVER
//   link_up       : registered filtered link status, high while state is UP
//   state         : current state (IDLE=0 RECOVER=1 WAIT_LOCK=2 WAIT_STATUS=3 UP=4)
//   fail_count    : saturating count of WAIT_LOCK / WAIT_STATUS timeouts
//   down_count    : saturating count of UP -> down transitions
//
// Build option:
//   TAXI_LINK_WDOG_BACKOFF_EN : exponential backoff of the WAIT_LOCK limit,
//   LOCK_TIMEOUT << k, where k counts consecutive timeouts up to MAX_BACKOFF.
// -----------------------------------------------------------------------------
module taxi_eth_link_wdog
  import taxi_link_wdog_pkg::*;
#(
  parameter int TIMER_W        = 24,
  parameter int LOCK_TIMEOUT   = 2000000,
  parameter int STATUS_TIMEOUT = 1000000,
  parameter int RST_PULSE      = 16,
  parameter int UP_FILTER      = 1024,
  parameter int DOWN_FILTER    = 8,
  parameter int CNT_W          = 16,
  parameter int MAX_BACKOFF    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             force_reset,
  input  logic             rx_block_lock,
  input  logic             rx_high_ber,
  input  logic             rx_status,
  output logic             rx_rst_req,
  output logic             link_up,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] down_count
);

  localparam logic [TIMER_W-1:0] PULSE_LAST  = TIMER_W'(RST_PULSE - 1);
  localparam logic [TIMER_W-1:0] STATUS_LAST = TIMER_W'(STATUS_TIMEOUT - 1);

  // Elaboration-time parameter checks
  if (longint'(LOCK_TIMEOUT) > (longint'(1) << TIMER_W)) begin : g_chk_lock
    $error("LOCK_TIMEOUT does not fit in TIMER_W");
  end
  if (longint'(STATUS_TIMEOUT) > (longint'(1) << TIMER_W)) begin : g_chk_status
    $error("STATUS_TIMEOUT does not fit in TIMER_W");
  end
  if (RST_PULSE < 1) begin : g_chk_pulse
    $error("RST_PULSE must be at least 1");
  end
  if (MAX_BACKOFF < 0) begin : g_chk_backoff
    $error("MAX_BACKOFF must not be negative");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] ber_sync;
  logic [SYNC_STAGES-1:0] status_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_sync   <= '0;
      ber_sync    <= '0;
      status_sync <= '0;
    end else begin
      lock_sync   <= {lock_sync[SYNC_STAGES-2:0], rx_block_lock};
      ber_sync    <= {ber_sync[SYNC_STAGES-2:0], rx_high_ber};
      status_sync <= {status_sync[SYNC_STAGES-2:0], rx_status};
    end
  end

  logic block_lock_s;
  logic high_ber_s;
  logic status_s;

  assign block_lock_s = lock_sync[SYNC_STAGES-1];
  assign high_ber_s   = ber_sync[SYNC_STAGES-1];
  assign status_s     = status_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce filters (each only runs while the FSM is in its own state)
  // ---------------------------------------------------------------------------
  wdog_state_t st;
  logic        up_done;
  logic        down_done;

  taxi_link_wdog_filter #(.N(UP_FILTER)) u_up_filter (
    .clk  (clk),
    .rst  (rst),
    .clr  (st != ST_WAIT_STATUS),
    .in   (status_s),
    .done (up_done)
  );

  taxi_link_wdog_filter #(.N(DOWN_FILTER)) u_down_filter (
    .clk  (clk),
    .rst  (rst),
    .clr  (st != ST_UP),
    .in   (!status_s || high_ber_s),
    .done (down_done)
  );

  // ---------------------------------------------------------------------------
  // Timeout limits
  // ---------------------------------------------------------------------------
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] lock_last;
  logic               lock_timeout;
  logic               status_timeout;

  assign lock_timeout   = (st == ST_WAIT_LOCK) && !block_lock_s && (timer == lock_last);
  // UP wins over a timeout landing in the same cycle
  assign status_timeout = (st == ST_WAIT_STATUS) && block_lock_s && !up_done &&
                          (timer == STATUS_LAST);

`ifdef TAXI_LINK_WDOG_BACKOFF_EN
  localparam int KW = (MAX_BACKOFF > 0) ? $clog2(MAX_BACKOFF + 1) : 1;
  localparam logic [KW-1:0] K_MAX = KW'(MAX_BACKOFF);

  if ((longint'(LOCK_TIMEOUT) << MAX_BACKOFF) > (longint'(1) << TIMER_W)) begin : g_chk_bo
    $error("LOCK_TIMEOUT << MAX_BACKOFF does not fit in TIMER_W");
  end

  logic [KW-1:0] k;
  logic          up_enter;

  assign up_enter  = (st == ST_WAIT_STATUS) && block_lock_s && up_done;
  assign lock_last = (TIMER_W'(LOCK_TIMEOUT) << k) - TIMER_W'(1);

  // Consecutive-failure count; only a successful link-up or an operator
  // action (disable / force) resets the backoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= '0;
    end else if (!enable || force_reset || up_enter) begin
      k <= '0;
    end else if ((lock_timeout || status_timeout) && (k != K_MAX)) begin
      k <= k + 1'b1;
    end
  end
`else
  assign lock_last = TIMER_W'(LOCK_TIMEOUT - 1);
`endif

  // ---------------------------------------------------------------------------
  // Recovery FSM; rx_rst_req and link_up are loaded together with the next
  // state so they track state exactly, with no extra output lag.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= ST_IDLE;
      timer      <= '0;
      rx_rst_req <= 1'b0;
      link_up    <= 1'b0;
      fail_count <= '0;
      down_count <= '0;
    end else if (!enable) begin
      st         <= ST_IDLE;
      timer      <= '0;
      rx_rst_req <= 1'b0;
      link_up    <= 1'b0;
    end else if (force_reset && (st != ST_IDLE)) begin
      st         <= ST_RECOVER;
      timer      <= '0;
      rx_rst_req <= 1'b1;
      link_up    <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          st         <= ST_RECOVER;
          timer      <= '0;
          rx_rst_req <= 1'b1;
          link_up    <= 1'b0;
        end
        ST_RECOVER: begin
          if (timer == PULSE_LAST) begin
            st         <= ST_WAIT_LOCK;
            timer      <= '0;
            rx_rst_req <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (block_lock_s) begin
            st    <= ST_WAIT_STATUS;
            timer <= '0;
          end else if (lock_timeout) begin
            st         <= ST_RECOVER;
            timer      <= '0;
            rx_rst_req <= 1'b1;
            fail_count <= sat_inc(fail_count);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_WAIT_STATUS: begin
          if (!block_lock_s) begin
            st    <= ST_WAIT_LOCK;
            timer <= '0;
          end else if (up_done) begin
            st      <= ST_UP;
            timer   <= '0;
            link_up <= 1'b1;
          end else if (status_timeout) begin
            st         <= ST_RECOVER;
            timer      <= '0;
            rx_rst_req <= 1'b1;
            fail_count <= sat_inc(fail_count);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_UP: begin
          // Link loss goes back to waiting for lock, never straight to reset
          if (down_done) begin
            st         <= ST_WAIT_LOCK;
            timer      <= '0;
            link_up    <= 1'b0;
            down_count <= sat_inc(down_count);
          end
        end
        default: begin
          st         <= ST_IDLE;
          timer      <= '0;
          rx_rst_req <= 1'b0;
          link_up    <= 1'b0;
        end
      endcase
    end
  end

  assign state = st;

endmodule
